// File: rtl/hx8352_reg_reader_if.sv
// Bundles the request/response handshake and the 8080-style LCD pins of the
// HX8352 register reader. The reader takes the master side, its environment the slave side.
interface hx8352_reg_reader_if;
    logic        req;
    logic [15:0] reg_addr;
    logic        dummy;
    logic        busy;
    logic        done;
    logic [15:0] rd_data;
    logic        lcd_cs;
    logic        lcd_rs;
    logic        lcd_wr;
    logic        lcd_rd;
    logic [15:0] lcd_data_out;
    logic        lcd_data_oe;
    logic [15:0] lcd_data_in;

    modport master (
        input  req, reg_addr, dummy, lcd_data_in,
        output busy, done, rd_data,
        output lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data_out, lcd_data_oe
    );

    modport slave (
        output req, reg_addr, dummy, lcd_data_in,
        input  busy, done, rd_data,
        input  lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data_out, lcd_data_oe
    );
endinterface

// File: rtl/hx8352_reg_reader.sv
// Read-side master for the HX8352 8080 parallel bus: index write, optional
// dummy read, then a data read whose word is returned on rd_data with a done pulse.
module hx8352_reg_reader #(
    parameter int T_WR_LOW  = 2,
    parameter int T_WR_HIGH = 2,
    parameter int T_RD_LOW  = 8,
    parameter int T_RD_HIGH = 4
) (
    input logic                clk,
    input logic                n_rst,
    hx8352_reg_reader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, IDX_SETUP, IDX_WR_LO, IDX_WR_HI, RD_SETUP, RD_LO, RD_HI, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [15:0] addr_q, addr_d;
    logic        dummy_q, dummy_d;
    logic        second_q, second_d;
    logic [15:0] shadow_q, shadow_d;

    logic        cs_q, cs_d;
    logic        rs_q, rs_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic        oe_q, oe_d;
    logic [15:0] dout_q, dout_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] rd_data_q, rd_data_d;

    logic        phase_last;
    logic        idx_phase;
    logic        bus_phase;

    // Counter value loaded on entry; a state is left once the counter reaches zero.
    function automatic logic [7:0] phase_len(state_t s);
        case (s)
            IDX_WR_LO: phase_len = 8'(T_WR_LOW - 1);
            IDX_WR_HI: phase_len = 8'(T_WR_HIGH - 1);
            RD_LO:     phase_len = 8'(T_RD_LOW - 1);
            RD_HI:     phase_len = 8'(T_RD_HIGH - 1);
            default:   phase_len = 8'd0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            phase_q   <= 8'd0;
            addr_q    <= 16'h0000;
            dummy_q   <= 1'b0;
            second_q  <= 1'b0;
            shadow_q  <= 16'h0000;
            cs_q      <= 1'b1;
            rs_q      <= 1'b1;
            wr_q      <= 1'b1;
            rd_q      <= 1'b1;
            oe_q      <= 1'b0;
            dout_q    <= 16'h0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            addr_q    <= addr_d;
            dummy_q   <= dummy_d;
            second_q  <= second_d;
            shadow_q  <= shadow_d;
            cs_q      <= cs_d;
            rs_q      <= rs_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            oe_q      <= oe_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        addr_d     = addr_q;
        dummy_d    = dummy_q;
        second_d   = second_q;
        shadow_d   = shadow_q;
        phase_last = (phase_q == 8'd0);

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    state_d  = IDX_SETUP;
                    addr_d   = bus.reg_addr;
                    dummy_d  = bus.dummy;
                    second_d = 1'b0;
                end
            end
            IDX_SETUP: state_d = IDX_WR_LO;
            IDX_WR_LO: if (phase_last) state_d = IDX_WR_HI;
            IDX_WR_HI: if (phase_last) state_d = RD_SETUP;
            RD_SETUP:  state_d = RD_LO;
            RD_LO: begin
                // RD has been low for the full access time, so the pads are settled.
                if (phase_last) begin
                    shadow_d = bus.lcd_data_in;
                    state_d  = RD_HI;
                end
            end
            RD_HI: begin
                if (phase_last) begin
                    if (dummy_q && !second_q) begin
                        state_d  = RD_LO;
                        second_d = 1'b1;
                    end else begin
                        state_d  = DONE;
                    end
                end
            end
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            phase_d = phase_len(state_d);
        end else if (!phase_last) begin
            phase_d = phase_q - 8'd1;
        end
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        idx_phase = (state_d == IDX_SETUP) || (state_d == IDX_WR_LO) || (state_d == IDX_WR_HI);
        bus_phase = idx_phase || (state_d == RD_SETUP) || (state_d == RD_LO) || (state_d == RD_HI);
        cs_d      = !bus_phase;
        rs_d      = !idx_phase;
        wr_d      = (state_d != IDX_WR_LO);
        rd_d      = (state_d != RD_LO);
        oe_d      = idx_phase;
        dout_d    = idx_phase ? addr_d : 16'h0000;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        rd_data_d = (state_d == DONE) ? shadow_q : rd_data_q;
    end

    assign bus.lcd_cs       = cs_q;
    assign bus.lcd_rs       = rs_q;
    assign bus.lcd_wr       = wr_q;
    assign bus.lcd_rd       = rd_q;
    assign bus.lcd_data_oe  = oe_q;
    assign bus.lcd_data_out = dout_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.rd_data      = rd_data_q;

endmodule

// File: tb/tb_hx8352_reg_reader.sv
// Scoreboard bench for hx8352_reg_reader: directed reads against a small panel
// model, with a monitor checking done timing, read data, strobe waveforms and bus rules.
module tb_hx8352_reg_reader;

    localparam int TWL = 2;
    localparam int TWH = 2;
    localparam int TRL = 8;
    localparam int TRH = 4;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   edge_cnt    = 0;

    typedef struct {
        logic [15:0] addr;
        bit          dummy;
        logic [15:0] data;
        int          latency;
        bit          abort;
        bit          gap_check;
    } exp_t;

    exp_t exp_q[$];

    logic [15:0] panel_mem [16];
    logic [3:0]  panel_wr = 4'd0;
    logic [3:0]  panel_rd = 4'd0;

    hx8352_reg_reader_if bus();

    hx8352_reg_reader #(
        .T_WR_LOW (TWL),
        .T_WR_HIGH(TWH),
        .T_RD_LOW (TRL),
        .T_RD_HIGH(TRH)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus.master)
    );

    always #10 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Panel model: presents the next queued word while RD is low, advances on each RD rise.
    assign bus.lcd_data_in = panel_mem[panel_rd];
    always @(posedge bus.lcd_rd) begin
        if (panel_rd != panel_wr) panel_rd <= panel_rd + 4'd1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic pushPanel(input logic [15:0] w);
        panel_mem[panel_wr] = w;
        panel_wr = panel_wr + 4'd1;
    endtask

    task automatic pushExp(input logic [15:0] addr, input bit dummy, input logic [15:0] data,
                           input int latency, input bit abort, input bit gap_check);
        exp_t e;
        e.addr      = addr;
        e.dummy     = dummy;
        e.data      = data;
        e.latency   = latency;
        e.abort     = abort;
        e.gap_check = gap_check;
        exp_q.push_back(e);
    endtask

    // Issues a single-cycle req; returns at the falling edge just after the accepting edge.
    task automatic applyStimulus(input logic [15:0] addr, input bit dummy, input logic [15:0] w0,
                                 input logic [15:0] w1, input logic [15:0] data, input int latency,
                                 input bit abort);
        pushPanel(w0);
        if (dummy) pushPanel(w1);
        pushExp(addr, dummy, data, latency, abort, 1'b0);
        @(negedge clk);
        bus.reg_addr = addr;
        bus.dummy    = dummy;
        bus.req      = 1'b1;
        @(negedge clk);
        bus.req      = 1'b0;
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        while ((bus.busy || exp_q.size() != 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= bound) begin
            miscompares++;
            $display("[TB] FAIL idle_timeout: still busy after %0d cycles, expected idle", n);
        end
    endtask

    exp_t mon_cur;
    bit   mon_active    = 1'b0;
    int   mon_start     = 0;
    int   mon_last_done = -100;
    int   mon_wave_err  = 0;
    int   mon_c;
    int   mon_rd0;
    int   mon_nrd;
    logic mon_viol;
    logic e_rs, e_wr, e_rd, e_oe;
    logic [15:0] e_dout;

    // Monitor: bus rules every cycle, per-transaction waveform, and done/rd_data against the scoreboard.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                if (mon_active) begin
                    checkOutput("abort_expected", 32'(mon_cur.abort), 32'd1);
                    mon_active = 1'b0;
                end
                continue;
            end

            mon_viol = (!bus.lcd_wr && !bus.lcd_rd) || (bus.lcd_data_oe && bus.lcd_rs) ||
                       (bus.lcd_data_oe && !bus.lcd_rd);
            if (!bus.busy)
                mon_viol = mon_viol || !bus.lcd_cs || !bus.lcd_wr || !bus.lcd_rd ||
                           bus.lcd_data_oe || bus.done;
            checkOutput("bus_rules", 32'(mon_viol), 32'd0);

            if (!mon_active && bus.busy) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_txn: busy rose with empty scoreboard, expected idle");
                    mon_cur.abort     = 1'b1;
                    mon_cur.latency   = 100;
                    mon_cur.dummy     = 1'b0;
                    mon_cur.addr      = 16'h0000;
                    mon_cur.data      = 16'h0000;
                    mon_cur.gap_check = 1'b0;
                end else begin
                    mon_cur = exp_q.pop_front();
                end
                mon_active   = 1'b1;
                mon_start    = edge_cnt;
                mon_wave_err = 0;
                if (mon_cur.gap_check)
                    checkOutput("idle_gap", 32'(mon_start - mon_last_done - 1), 32'd1);
            end

            if (mon_active) begin
                mon_c   = edge_cnt - mon_start + 1;
                mon_nrd = mon_cur.dummy ? 2 : 1;
                mon_rd0 = 3 + TWL + TWH;
                if (bus.done) begin
                    checkOutput("done_cycle", 32'(mon_c), 32'(mon_cur.latency));
                    checkOutput("rd_data", 32'(bus.rd_data), 32'(mon_cur.data));
                    checkOutput("done_not_aborted", 32'(mon_cur.abort), 32'd0);
                    checkOutput("waveform_errs", 32'(mon_wave_err), 32'd0);
                    checkOutput("done_cs_high", 32'(bus.lcd_cs), 32'd1);
                    mon_last_done = edge_cnt;
                    mon_active    = 1'b0;
                end else if (mon_c > mon_cur.latency + 2) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL done_timeout: no done by cycle %0d, expected cycle %0d",
                             mon_c, mon_cur.latency);
                    mon_active = 1'b0;
                end else begin
                    if (mon_c < mon_rd0 - 1) begin
                        e_rs   = 1'b0;
                        e_oe   = 1'b1;
                        e_dout = mon_cur.addr;
                        e_wr   = !(mon_c >= 2 && mon_c <= 1 + TWL);
                        e_rd   = 1'b1;
                    end else begin
                        e_rs   = 1'b1;
                        e_oe   = 1'b0;
                        e_dout = 16'h0000;
                        e_wr   = 1'b1;
                        e_rd   = !(mon_c >= mon_rd0 && mon_c < mon_rd0 + mon_nrd * (TRL + TRH) &&
                                   ((mon_c - mon_rd0) % (TRL + TRH)) < TRL);
                    end
                    if (bus.lcd_cs !== 1'b0 || bus.lcd_rs !== e_rs || bus.lcd_wr !== e_wr ||
                        bus.lcd_rd !== e_rd || bus.lcd_data_oe !== e_oe ||
                        bus.lcd_data_out !== e_dout || bus.busy !== 1'b1)
                        mon_wave_err++;
                end
            end
        end
    end

    initial begin : stimulus
        for (int i = 0; i < 16; i++) panel_mem[i] = 16'h0000;
        bus.req      = 1'b0;
        bus.reg_addr = 16'h0000;
        bus.dummy    = 1'b0;
        n_rst        = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (10) @(negedge clk);

        checkOutput("rst_cs", 32'(bus.lcd_cs), 32'd1);
        checkOutput("rst_rs", 32'(bus.lcd_rs), 32'd1);
        checkOutput("rst_wr", 32'(bus.lcd_wr), 32'd1);
        checkOutput("rst_rd", 32'(bus.lcd_rd), 32'd1);
        checkOutput("rst_oe", 32'(bus.lcd_data_oe), 32'd0);
        checkOutput("rst_dout", 32'(bus.lcd_data_out), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_rd_data", 32'(bus.rd_data), 32'h0000);

        $display("[TB] plain register read");
        applyStimulus(16'h0000, 1'b0, 16'h0052, 16'h0000, 16'h0052, 19, 1'b0);
        waitIdle(60);

        $display("[TB] GRAM read with dummy cycle");
        applyStimulus(16'h0022, 1'b1, 16'hDEAD, 16'hF800, 16'hF800, 31, 1'b0);
        waitIdle(80);

        $display("[TB] req while busy is ignored");
        applyStimulus(16'h1234, 1'b0, 16'h00C3, 16'h0000, 16'h00C3, 19, 1'b0);
        repeat (4) @(negedge clk);
        bus.reg_addr = 16'hBEEF;
        bus.req      = 1'b1;
        @(negedge clk);
        bus.req      = 1'b0;
        waitIdle(60);
        repeat (5) @(negedge clk);
        checkOutput("rd_data_hold", 32'(bus.rd_data), 32'h00C3);
        checkOutput("idle_after_ignored", 32'(bus.busy), 32'd0);

        $display("[TB] req held high for 60 cycles");
        pushPanel(16'h0111);
        pushPanel(16'h0222);
        pushPanel(16'h0333);
        pushExp(16'h0000, 1'b0, 16'h0111, 19, 1'b0, 1'b0);
        pushExp(16'h0000, 1'b0, 16'h0222, 19, 1'b0, 1'b1);
        pushExp(16'h0000, 1'b0, 16'h0333, 19, 1'b0, 1'b1);
        @(negedge clk);
        bus.reg_addr = 16'h0000;
        bus.dummy    = 1'b0;
        bus.req      = 1'b1;
        repeat (60) @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        waitIdle(40);

        $display("[TB] reset during RD low");
        applyStimulus(16'h00AA, 1'b0, 16'h1234, 16'h0000, 16'h1234, 19, 1'b1);
        repeat (9) @(negedge clk);
        checkOutput("rd_low_before_reset", 32'(bus.lcd_rd), 32'd0);
        #3 n_rst = 1'b0;
        #1;
        checkOutput("async_rst_rd", 32'(bus.lcd_rd), 32'd1);
        checkOutput("async_rst_cs", 32'(bus.lcd_cs), 32'd1);
        checkOutput("async_rst_done", 32'(bus.done), 32'd0);
        checkOutput("async_rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("async_rst_rd_data", 32'(bus.rd_data), 32'h0000);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post_rst_rd_data", 32'(bus.rd_data), 32'h0000);
        checkOutput("post_rst_done", 32'(bus.done), 32'd0);

        applyStimulus(16'h0000, 1'b0, 16'h0052, 16'h0000, 16'h0052, 19, 1'b0);
        waitIdle(60);
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
